// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU operation encodings and
// default datapath, address and register-index widths.
package ex_pkg;

  localparam int unsigned N_DEF = 64;
  localparam int unsigned W_DEF = 32;
  localparam int unsigned R_DEF = 5;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_NOR  = 4'b0100,
    ALU_RSV5 = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SLL  = 4'b1001,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_ADDW = 4'b1100,
    ALU_SUBW = 4'b1101
  } alu_op_e;

endpackage

// File: rtl/ex_alu.sv
// Combinational N-bit ALU with zero flag; overflow wraps silently and
// unlisted encodings produce 0.
module ex_alu
  import ex_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic [N-1:0] srca,
  input  logic [N-1:0] srcb,
  input  logic [3:0]   alucontrol,
  output logic [N-1:0] result,
  output logic         zero
);

  localparam int unsigned SH = $clog2(N);

  logic [SH-1:0] shamt_s;
  logic [N-1:0]  sum_s;
  logic [N-1:0]  diff_s;

  assign shamt_s = srcb[SH-1:0];
  assign sum_s   = srca + srcb;
  assign diff_s  = srca - srcb;

  // Operation select; word ops sign-extend bit 31 of the full-width result.
  always_comb begin
    result = '0;
    case (alu_op_e'(alucontrol))
      ALU_AND:  result = srca & srcb;
      ALU_OR:   result = srca | srcb;
      ALU_ADD:  result = sum_s;
      ALU_XOR:  result = srca ^ srcb;
      ALU_NOR:  result = ~(srca | srcb);
      ALU_SUB:  result = diff_s;
      ALU_SLT:  result = {{(N-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      ALU_SLTU: result = {{(N-1){1'b0}}, (srca < srcb)};
      ALU_SLL:  result = srca << shamt_s;
      ALU_SRL:  result = srca >> shamt_s;
      ALU_SRA:  result = $unsigned($signed(srca) >>> shamt_s);
      ALU_ADDW: result = {{(N-32){sum_s[31]}}, sum_s[31:0]};
      ALU_SUBW: result = {{(N-32){diff_s[31]}}, diff_s[31:0]};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_pipereg.sv
// Generic WIDTH-bit pipeline flop with asynchronous active-low clear;
// loads on every rising clock edge.
module ex_pipereg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_d,
  output logic [WIDTH-1:0] data_q
);

  // Unconditional capture; clear discards any in-flight value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage: ALU, address adder and the E->M pipeline register holding
// ALU result, store data and destination register index.
module ex_stage_unit
  import ex_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF,
  parameter int unsigned R = R_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] srca,
  input  logic [N-1:0] srcb,
  input  logic [3:0]   alucontrol,
  input  logic [N-1:0] writedata_e,
  input  logic [R-1:0] writereg_e,
  input  logic [W-1:0] adda,
  input  logic [W-1:0] addb,
  output logic [W-1:0] sum,
  output logic [N-1:0] aluout_e,
  output logic         zero,
  output logic [N-1:0] aluout_m,
  output logic [N-1:0] writedata_m,
  output logic [R-1:0] writereg_m
);

  localparam int unsigned PW = 2 * N + R;

  logic [PW-1:0] pipe_d;
  logic [PW-1:0] pipe_q;

  assign sum = adda + addb;

  ex_alu #(.N(N)) u_alu (
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .result     (aluout_e),
    .zero       (zero)
  );

  // Pack the E->M payload.
  always_comb begin
    pipe_d = {aluout_e, writedata_e, writereg_e};
  end

  ex_pipereg #(.WIDTH(PW)) u_pipe (
    .clk    (clk),
    .rst_n  (reset),
    .data_d (pipe_d),
    .data_q (pipe_q)
  );

  assign aluout_m    = pipe_q[PW-1 -: N];
  assign writedata_m = pipe_q[R +: N];
  assign writereg_m  = pipe_q[R-1:0];

endmodule

// File: tb/tb_ex_stage_unit.sv
// Self-checking bench for ex_stage_unit: directed literal cases plus randomized
// traffic compared every cycle against a behavioural model.
module tb_ex_stage_unit;

  logic        clk;
  logic        reset;
  logic [63:0] srca, srcb, writedata_e;
  logic [3:0]  alucontrol;
  logic [4:0]  writereg_e;
  logic [31:0] adda, addb;
  logic [31:0] sum;
  logic [63:0] aluout_e, aluout_m, writedata_m;
  logic        zero;
  logic [4:0]  writereg_m;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  logic [63:0] exp_alu_m, exp_wd_m;
  logic [4:0]  exp_wr_m;

  ex_stage_unit dut (
    .clk(clk), .reset(reset), .srca(srca), .srcb(srcb), .alucontrol(alucontrol),
    .writedata_e(writedata_e), .writereg_e(writereg_e), .adda(adda), .addb(addb),
    .sum(sum), .aluout_e(aluout_e), .zero(zero), .aluout_m(aluout_m),
    .writedata_m(writedata_m), .writereg_m(writereg_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] t;
    int sh;
    bit lt;
    sh = int'(b[5:0]);
    case (int'(op))
      0: return a & b;
      1: return a | b;
      2: return a + b;
      3: return a ^ b;
      4: return ~(a | b);
      6: return a - b;
      7: begin
        if (a[63] != b[63]) lt = a[63];
        else lt = (a < b);
        return lt ? 64'd1 : 64'd0;
      end
      8: return (a < b) ? 64'd1 : 64'd0;
      9: begin
        t = a;
        for (int i = 0; i < sh; i++) t = t * 64'd2;
        return t;
      end
      10: begin
        t = a;
        for (int i = 0; i < sh; i++) t = t / 64'd2;
        return t;
      end
      11: begin
        t = a;
        for (int i = 0; i < sh; i++) t = {t[63], t[63:1]};
        return t;
      end
      12: begin
        t = a + b;
        return t[31] ? {32'hFFFF_FFFF, t[31:0]} : {32'h0, t[31:0]};
      end
      13: begin
        t = a - b;
        return t[31] ? {32'hFFFF_FFFF, t[31:0]} : {32'h0, t[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, expv);
    end
  endtask

  // Reference E->M register: follows reset asynchronously, captures on each edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_alu_m = 64'd0;
      exp_wd_m  = 64'd0;
      exp_wr_m  = 5'd0;
    end else begin
      exp_alu_m = ref_alu(alucontrol, srca, srcb);
      exp_wd_m  = writedata_e;
      exp_wr_m  = writereg_e;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      logic [63:0] e;
      e = ref_alu(alucontrol, srca, srcb);
      chk("cyc_aluout_e", aluout_e, e);
      chk("cyc_zero", {63'd0, zero}, {63'd0, (e == 64'd0)});
      chk("cyc_sum", {32'd0, sum}, {32'd0, adda + addb});
      chk("cyc_aluout_m", aluout_m, exp_alu_m);
      chk("cyc_writedata_m", writedata_m, exp_wd_m);
      chk("cyc_writereg_m", {59'd0, writereg_m}, {59'd0, exp_wr_m});
    end
  end

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] wd, input logic [4:0] wr);
    alucontrol = op; srca = a; srcb = b; writedata_e = wd; writereg_e = wr;
  endtask

  task automatic comb(input string name, input logic [3:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] expv, input bit expz);
    drive(op, a, b, writedata_e, writereg_e);
    #1;
    chk(name, aluout_e, expv);
    chk({name, "_zero"}, {63'd0, zero}, {63'd0, expz});
    chk({name, "_model"}, ref_alu(op, a, b), expv);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    drive(4'b0010, 64'd11, 64'd22, 64'hDEAD_BEEF, 5'd9);
    adda = 32'd0; addb = 32'd0;
    after_edge();
    after_edge();
    // 1. async reset with nonzero inputs, no clock edge required
    reset = 1'b0;
    #1;
    chk("rst_aluout_m", aluout_m, 64'd0);
    chk("rst_writedata_m", writedata_m, 64'd0);
    chk("rst_writereg_m", {59'd0, writereg_m}, 64'd0);
    after_edge();
    chk("rst_hold_aluout_m", aluout_m, 64'd0);
    drive(4'b0010, 64'd5, 64'd3, 64'd0, 5'd0);
    reset = 1'b1;
    after_edge();
    chk("rst_release_add", aluout_m, 64'd8);

    // 2-4. directed ALU cases
    comb("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
    comb("sub_neg", 4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    comb("addw_ovf", 4'b1100, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0);
    comb("slt", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0);
    comb("sltu", 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
    comb("nor", 4'b0100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    comb("sll63", 4'b1001, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0);
    comb("sra63", 4'b1011, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    comb("srl63", 4'b1010, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0);
    comb("reserved5", 4'b0101, 64'h1234, 64'h5678, 64'd0, 1'b1);
    comb("subw_neg", 4'b1101, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // 5. address adder
    adda = 32'h0040_0000; addb = 32'd4; #1;
    chk("sum_pc4", {32'd0, sum}, 64'h0040_0004);
    adda = 32'hFFFF_FFFC; addb = 32'd4; #1;
    chk("sum_wrap", {32'd0, sum}, 64'd0);

    // 6. pipeline ordering with a reset pulse before the third capture
    drive(4'b0010, 64'h1111, 64'd0, 64'hA1, 5'd1);
    after_edge();
    chk("pipe1_alu", aluout_m, 64'h1111);
    chk("pipe1_wd", writedata_m, 64'hA1);
    chk("pipe1_wr", {59'd0, writereg_m}, 64'd1);
    drive(4'b0010, 64'h2222, 64'd0, 64'hB2, 5'd2);
    after_edge();
    chk("pipe2_alu", aluout_m, 64'h2222);
    chk("pipe2_wd", writedata_m, 64'hB2);
    chk("pipe2_wr", {59'd0, writereg_m}, 64'd2);
    drive(4'b0010, 64'h3333, 64'd0, 64'hC3, 5'd31);
    reset = 1'b0;
    #1;
    chk("pipe_rst_alu", aluout_m, 64'd0);
    chk("pipe_rst_wr", {59'd0, writereg_m}, 64'd0);
    reset = 1'b1;
    after_edge();
    chk("pipe3_alu", aluout_m, 64'h3333);
    chk("pipe3_wd", writedata_m, 64'hC3);
    chk("pipe3_wr", {59'd0, writereg_m}, 64'd31);

    // randomized traffic checked every cycle by the compare process
    check_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = 64'($urandom_range(0, 63));
        2: a = {32'd0, $urandom};
        default: ;
      endcase
      drive(4'($urandom_range(0, 15)), a, b, {$urandom, $urandom}, 5'($urandom));
      adda = $urandom; addb = $urandom;
      if ($urandom_range(0, 39) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
      after_edge();
    end
    check_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
